// File: rtl/euler_arbiter.sv
// Round-robin front end that shares one euler core among NREQ requesters,
// keeping exactly one job in flight from accept through result delivery.
// IDLE: arbitrate | ISSUE: call core | WAIT: await return | RESP: deliver result
module euler_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_n,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [63:0]          resp_data,
  input  logic [NREQ-1:0]      resp_ready,
  output logic                 core_start,
  input  logic                 core_busy,
  output logic [31:0]          core_n,
  input  logic                 core_done,
  output logic                 core_stall,
  input  logic [63:0]          core_returndata,
  output logic                 active,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    grant_q;
  logic [31:0]       n_q;
  logic [63:0]       res_q;
  logic              core_start_q;
  logic              core_stall_q;
  logic              active_q;
  logic [NREQ-1:0]   resp_valid_q;

  logic [IDW-1:0]    ptr_d;
  logic [IDW:0]      cand;
  logic              win_found;
  logic [IDW-1:0]    win_id;
  logic [NREQ-1:0]   win_onehot;
  logic [NREQ-1:0]   grant_onehot;

  // Rotating priority: scan from ptr_q upward, wrapping at NREQ.
  always_comb begin
    cand      = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[win_id] = 1'b1;
  end

  always_comb begin
    grant_onehot          = '0;
    grant_onehot[grant_q] = 1'b1;
  end

  always_comb begin
    if (grant_q == IDW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_q + IDW'(1);
    end
  end

  // Reset is folded in so req_ready reads zero while reset is held.
  assign req_ready = (state_q == IDLE && win_found && !reset) ? win_onehot : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      n_q          <= '0;
      res_q        <= '0;
      core_start_q <= 1'b0;
      core_stall_q <= 1'b1;
      active_q     <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            n_q          <= req_n[{win_id, 5'b0} +: 32];
            grant_q      <= win_id;
            core_start_q <= 1'b1;
            active_q     <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!core_busy) begin
            core_start_q <= 1'b0;
            core_stall_q <= 1'b0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            res_q        <= core_returndata;
            core_stall_q <= 1'b1;
            resp_valid_q <= grant_onehot;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[grant_q]) begin
            ptr_q        <= ptr_d;
            resp_valid_q <= '0;
            active_q     <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_stall = core_stall_q;
  assign core_n     = n_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = res_q;
  assign active     = active_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_euler_arbiter.sv
// Scoreboard bench for euler_arbiter: a transaction-level model predicts grants,
// core calls and returned results; a behavioural euler core answers the calls.
module tb_euler_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_n;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     resp_valid;
  logic [63:0]         resp_data;
  logic [NREQ-1:0]     resp_ready;
  logic                core_start;
  logic                core_busy;
  logic [31:0]         core_n;
  logic                core_done;
  logic                core_stall;
  logic [63:0]         core_returndata;
  logic                active;
  logic [IDW-1:0]      grant_id;

  int checks   = 0;
  int failures = 0;

  int lat_min    = 0;
  int lat_max    = 0;
  bit busy_force = 1'b0;
  bit busy_val   = 1'b0;
  bit busy_rand  = 1'b0;
  bit spur_rand  = 1'b0;
  int spur_req   = 0;

  euler_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .core_start(core_start), .core_busy(core_busy), .core_n(core_n),
    .core_done(core_done), .core_stall(core_stall),
    .core_returndata(core_returndata),
    .active(active), .grant_id(grant_id)
  );

  initial forever #5 clock = ~clock;

  function automatic int gcd(input int a, input int b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = y; y = x % y; x = t; end
    return x;
  endfunction

  function automatic logic [31:0] phi8(input logic [7:0] v);
    int cnt;
    cnt = 0;
    for (int k = 1; k <= int'(v); k++) if (gcd(k, int'(v)) == 1) cnt++;
    return 32'(cnt);
  endfunction

  // What the behavioural core returns for argument n.
  function automatic logic [63:0] core_result(input logic [31:0] n);
    return {n[31:8], n[31:24], phi8(n[7:0])};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'(0));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_resp_data"},  resp_data,       64'(0));
    chk({tag, "_core_start"}, 64'(core_start), 64'(0));
    chk({tag, "_core_n"},     64'(core_n),     64'(0));
    chk({tag, "_core_stall"}, 64'(core_stall), 64'(1));
    chk({tag, "_active"},     64'(active),     64'(0));
    chk({tag, "_grant_id"},   64'(grant_id),   64'(0));
  endtask

  // Transaction model: one job at a time walks accept -> call -> return -> delivery.
  task automatic monitor_proc();
    int              exp_id[$];
    logic [31:0]     exp_n[$];
    int              phase, mptr, w;
    logic [NREQ-1:0] exp_rdy;
    phase = 0; mptr = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_id.delete(); exp_n.delete();
        phase = 0; mptr = 0;
        chk_reset_outputs("rst_hold");
        continue;
      end
      chk("active",     64'(active),     64'(phase != 0));
      chk("core_start", 64'(core_start), 64'(phase == 1));
      chk("core_stall", 64'(core_stall), 64'(phase != 2));
      w = (phase == 0) ? rr_pick(req_valid, mptr) : -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (phase != 0) begin
        chk("grant_id", 64'(grant_id), 64'(exp_id[0]));
        if (phase == 1) chk("core_n", 64'(core_n), 64'(exp_n[0]));
      end
      if (phase == 3) begin
        chk("resp_valid", 64'(resp_valid), 64'(1) << exp_id[0]);
        chk("resp_data",  resp_data, core_result(exp_n[0]));
      end else begin
        chk("resp_valid_idle", 64'(resp_valid), 64'(0));
      end
      case (phase)
        0: if (w >= 0) begin
             exp_id.push_back(w);
             exp_n.push_back(req_n[32*w +: 32]);
             phase = 1;
           end
        1: if (!core_busy) phase = 2;
        2: if (core_done) phase = 3;
        3: if (resp_ready[exp_id[0]]) begin
             mptr = (exp_id[0] + 1) % NREQ;
             void'(exp_id.pop_front());
             void'(exp_n.pop_front());
             phase = 0;
           end
        default: phase = 0;
      endcase
    end
  endtask

  // Behavioural euler core with configurable call backpressure and latency.
  task automatic core_proc();
    bit          outst, stale, take, ret;
    int          cnt, spur_seen;
    logic [31:0] cn, ns;
    outst = 0; stale = 0; cnt = 0; spur_seen = 0; cn = '0;
    core_busy = 1'b0; core_done = 1'b0; core_returndata = '0;
    forever begin
      @(negedge clock);
      take = core_start && !core_busy && !outst;
      ret  = core_done && !core_stall && outst;
      ns   = core_n;
      @(posedge clock);
      #1;
      if (reset) begin
        if (outst) stale = 1;
        outst = 0; core_done = 1'b0; core_busy = 1'b0;
        continue;
      end
      core_done = 1'b0;
      if (ret) outst = 0;
      if (take) begin
        outst = 1; cn = ns;
        cnt = int'($urandom_range(lat_max, lat_min));
      end
      if (outst) begin
        if (cnt == 0) begin
          core_done = 1'b1;
          core_returndata = core_result(cn);
        end else begin
          cnt--;
        end
      end else if (stale) begin
        core_done = 1'b1; core_returndata = {$urandom, $urandom}; stale = 0;
      end else if (spur_req != spur_seen) begin
        core_done = 1'b1; core_returndata = {$urandom, $urandom}; spur_seen = spur_req;
      end else if (spur_rand && $urandom_range(0, 15) == 0) begin
        core_done = 1'b1; core_returndata = {$urandom, $urandom};
      end
      if (busy_force)     core_busy = busy_val;
      else if (busy_rand) core_busy = ($urandom_range(0, 2) == 0);
      else                core_busy = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    @(negedge clock);
    while (active && c < 300) begin @(negedge clock); c++; end
    if (active) timeout({tag, "_idle"});
    @(posedge clock);
    #1;
  endtask

  task automatic wait_accept(input int idx, input string tag);
    int c;
    bit ok;
    c = 0; ok = 0;
    while (c < 60) begin
      @(negedge clock);
      if (req_valid[idx] && req_ready[idx]) begin ok = 1; break; end
      c++;
    end
    if (!ok) timeout({tag, "_accept"});
    @(posedge clock);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int c;
    c = 0;
    @(negedge clock);
    while (resp_valid == '0 && c < 300) begin @(negedge clock); c++; end
    if (resp_valid == '0) timeout({tag, "_resp"});
  endtask

  task automatic sync_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0]     n1;
    logic [NREQ-1:0] acc;
    int              order[5];
    int              ng, starts, c;
    bit              prev_done, saw;

    reset = 1'b1; req_valid = '0; req_n = '0; resp_ready = '1;
    fork
      monitor_proc();
      core_proc();
    join_none
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    // Single job: requester 2, n = 10, totient 4.
    lat_min = 4; lat_max = 4;
    req_n[2*32 +: 32] = 32'd10;
    req_valid[2] = 1'b1;
    wait_accept(2, "single");
    @(negedge clock);
    chk("single_start_lat", 64'(core_start), 64'(1));
    chk("single_core_n", 64'(core_n), 64'(10));
    prev_done = 0; saw = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (resp_valid != '0) begin saw = 1; break; end
      prev_done = core_done;
    end
    if (!saw) timeout("single_resp");
    chk("single_resp_after_done", 64'(prev_done), 64'(1));
    chk("single_resp_valid", 64'(resp_valid), 64'(4'b0100));
    chk("single_resp_data", resp_data, 64'h0000_0000_0000_0004);
    wait_idle("single");

    // Round robin from reset with all requesters continuously valid.
    sync_reset();
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < NREQ; i++) req_n[32*i +: 32] = $urandom;
    req_valid = '1;
    ng = 0; c = 0;
    while (ng < 5 && c < 400) begin
      @(negedge clock);
      acc = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) if (acc[i]) begin order[ng] = i; ng++; end
      c++;
    end
    if (ng < 5) timeout("rr_grants");
    @(posedge clock);
    #1;
    req_valid = '0;
    for (int i = 0; i < ng; i++) chk("rr_order", 64'(order[i]), 64'(i % NREQ));
    wait_idle("rr");

    // Core backpressure: core_busy high for the first three ISSUE cycles.
    busy_force = 1; busy_val = 1;
    n1 = $urandom;
    req_n[0 +: 32] = n1;
    req_valid[0] = 1'b1;
    wait_accept(0, "busy");
    @(negedge clock);
    starts = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      if (core_start && core_n == n1 && core_stall) starts++;
      if (k == 2) busy_val = 0;
    end
    chk("busy_start_cycles", 64'(starts), 64'(4));
    @(negedge clock);
    chk("busy_start_drop", 64'(core_start), 64'(0));
    chk("busy_wait_entry", 64'(core_stall), 64'(0));
    busy_force = 0;
    wait_idle("busy");

    // Response backpressure with a competing requester.
    resp_ready = 4'b1101;
    n1 = $urandom;
    req_n[1*32 +: 32] = n1;
    req_n[3*32 +: 32] = $urandom;
    req_valid[1] = 1'b1;
    wait_accept(1, "bp");
    req_valid[3] = 1'b1;
    wait_resp("bp");
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clock);
      chk("bp_resp_valid", 64'(resp_valid), 64'(4'b0010));
      chk("bp_resp_data", resp_data, core_result(n1));
      chk("bp_competitor_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clock);
    #1;
    resp_ready = '1;
    @(negedge clock);
    chk("bp_ready_at_hs", 64'(req_ready), 64'(0));
    @(negedge clock);
    chk("bp_next_grant", 64'(req_ready), 64'(4'b1000));
    @(posedge clock);
    #1;
    req_valid[3] = 1'b0;
    wait_idle("bp");

    // Reset asserted while waiting for the core.
    lat_min = 10; lat_max = 10;
    req_n[0 +: 32] = $urandom;
    req_valid[0] = 1'b1;
    wait_accept(0, "rstw");
    c = 0;
    @(negedge clock);
    while (core_stall && c < 20) begin @(negedge clock); c++; end
    if (core_stall) timeout("rstw_wait");
    #2 reset = 1'b1;
    #1 chk_reset_outputs("rst_async");
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("rstw_no_resp", 64'(resp_valid), 64'(0));
      chk("rstw_idle", 64'(active), 64'(0));
    end
    @(posedge clock);
    #1;
    lat_min = 0; lat_max = 3;
    n1 = $urandom;
    req_n[3*32 +: 32] = n1;
    req_valid[3] = 1'b1;
    wait_accept(3, "rstw_next");
    wait_resp("rstw_next");
    chk("rstw_next_valid", 64'(resp_valid), 64'(4'b1000));
    chk("rstw_next_data", resp_data, core_result(n1));
    wait_idle("rstw_next");

    // Spurious core_done while idle.
    spur_req++;
    saw = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (core_done) begin saw = 1; break; end
    end
    chk("spur_driven", 64'(saw), 64'(1));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      chk("spur_no_resp", 64'(resp_valid), 64'(0));
      chk("spur_idle", 64'(active), 64'(0));
    end
    @(posedge clock);
    #1;

    // Randomised traffic.
    busy_rand = 1; spur_rand = 1; lat_min = 0; lat_max = 6;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_n[32*i +: 32] = $urandom;
        end
      end
      resp_ready = NREQ'($urandom);
    end
    req_valid = '0; resp_ready = '1; busy_rand = 0; spur_rand = 0;
    wait_idle("drain");
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
